// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types and constants for the sequential ALU.
//   op_e    - 3-bit opcode encoding presented on seq_alu.op
//   state_e - control FSM states (IDLE accepts, BUSY iterates, DONE presents)
package seq_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_MUL = 3'd6,
    OP_DIV = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative unsigned multiply / restoring divide, one bit per cycle.
//   clk, rst      - clock, async active-high reset
//   start         - load operands and begin; one-cycle pulse
//   is_mul        - 1 = multiply, 0 = divide (sampled with start)
//   a, b          - operands (dividend/divisor for divide)
//   done          - high in the cycle whose clock edge completes the last step
//   res           - final value, valid while done: product or {remainder, quotient}
// Multiplier registers exist only when SEQ_ALU_MUL_EN is defined.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_mul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] res
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH:0]   trial;
  logic             ge;

  // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
  // The difference always fits in WIDTH bits because remainder < divisor.
  assign trial  = {rem_q, quo_q[WIDTH-1]};
  assign ge     = trial >= {1'b0, dvs_q};
  assign rem_nx = ge ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ge};

`ifdef SEQ_ALU_MUL_EN
  logic             mul_q, mul_d;
  logic [RW-1:0]    prod_q, prod_d, mcand_q, mcand_d, prod_nx;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  // Shift-add: multiplier consumed LSB first, multiplicand shifts left each step.
  assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);
`else
  logic unused_is_mul;
  assign unused_is_mul = is_mul;
`endif

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    done   = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    mul_d    = mul_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    res      = mul_q ? prod_nx : {rem_nx, quo_nx};
`else
    res      = {rem_nx, quo_nx};
`endif
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = a;
      dvs_d  = b;
`ifdef SEQ_ALU_MUL_EN
      mul_d    = is_mul;
      prod_d   = '0;
      mcand_d  = RW'(a);
      mplier_d = b;
`endif
    end else if (busy_q) begin
      rem_d = rem_nx;
      quo_d = quo_nx;
      cnt_d = cnt_q + CW'(1);
`ifdef SEQ_ALU_MUL_EN
      prod_d   = prod_nx;
      mcand_d  = {mcand_q[RW-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
`endif
      if (cnt_q == LAST) begin
        done   = 1'b1;
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
`ifdef SEQ_ALU_MUL_EN
      mul_q    <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
`ifdef SEQ_ALU_MUL_EN
      mul_q    <= mul_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: single-command sequential ALU with valid/ready handshakes.
//   clk, rst             - clock, async active-high reset
//   in_valid / in_ready  - command handshake; in_ready only in IDLE
//   a, b, op             - operands and opcode (see seq_alu_pkg::op_e)
//   out_valid / out_ready- result handshake; out_valid only in DONE
//   result, zero, err    - 2*WIDTH result, result==0 flag, div-by-zero / disabled-op flag
// Logic ops finish in one cycle; MUL/DIV iterate WIDTH cycles in seq_alu_muldiv.
// Define SEQ_ALU_MUL_EN to build the multiplier; otherwise MUL returns err.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [OP_W-1:0]    op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               err
);

  localparam int RW = 2 * WIDTH;

  state_e        state_q, state_d;
  logic [RW-1:0] result_q, result_d;
  logic          zero_q, zero_d, err_q, err_d;
  logic [RW-1:0] a_x, b_x, alu_res, md_res;
  logic          md_start, md_done, md_ok;
  op_e           op_c;

  assign op_c = op_e'(op);
  assign a_x  = RW'(a);
  assign b_x  = RW'(b);

  // Commands that go through the iterative unit; everything else completes in IDLE.
`ifdef SEQ_ALU_MUL_EN
  assign md_ok = (op_c == OP_MUL) || ((op_c == OP_DIV) && (b != '0));
`else
  assign md_ok = (op_c == OP_DIV) && (b != '0);
`endif

  always_comb begin
    alu_res = '0;
    case (op_c)
      OP_ADD:  alu_res = a_x + b_x;
      OP_SUB:  alu_res = a_x - b_x;
      OP_AND:  alu_res = a_x & b_x;
      OP_OR:   alu_res = a_x | b_x;
      OP_XOR:  alu_res = a_x ^ b_x;
      OP_NOT:  alu_res = {~b, ~a};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    md_start = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid) begin
        if (md_ok) begin
          md_start = 1'b1;
          state_d  = S_BUSY;
        end else begin
          // MUL/DIV that reach here are div-by-zero or a disabled multiplier
          state_d  = S_DONE;
          err_d    = (op_c == OP_MUL) || (op_c == OP_DIV);
          result_d = alu_res;
          zero_d   = (alu_res == '0);
        end
      end
      S_BUSY: if (md_done) begin
        state_d  = S_DONE;
        result_d = md_res;
        zero_d   = (md_res == '0);
        err_d    = 1'b0;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_mul (op_c == OP_MUL),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .res    (md_res)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0, b = '0;
  logic [2:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        zero, err;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: {err, result} straight from the arithmetic definition of each opcode.
  function automatic logic [16:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int s;
    logic [7:0] q, r;
    case (o)
      3'd0: begin s = int'(x) + int'(y); return {1'b0, s[15:0]}; end
      3'd1: begin s = int'(x) - int'(y); return {1'b0, s[15:0]}; end
      3'd2: return {1'b0, 8'h00, x & y};
      3'd3: return {1'b0, 8'h00, x | y};
      3'd4: return {1'b0, 8'h00, x ^ y};
      3'd5: return {1'b0, ~y, ~x};
`ifdef SEQ_ALU_MUL_EN
      3'd6: begin s = int'(x) * int'(y); return {1'b0, s[15:0]}; end
`else
      3'd6: return {1'b1, 16'h0000};
`endif
      default: begin
        if (y == 8'd0) return {1'b1, 16'h0000};
        q = x / y;
        r = x % y;
        return {1'b0, r, q};
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [7:0] y);
`ifdef SEQ_ALU_MUL_EN
    if (o == 3'd6) return 9;
`endif
    if (o == 3'd7 && y != 8'd0) return 9;
    return 1;
  endfunction

  // Issue one command, wait for the result (bounded), hold off out_ready for
  // 'hold' cycles, then complete the handshake. Garbage is driven on the
  // command inputs while the block is busy to show it is ignored.
  task automatic do_op(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb,
                       input int hold, output logic [15:0] r, output logic e,
                       output logic z, output int lat, output bit rdy_low);
    op = o; a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1; rdy_low = 1'b1;
    in_valid = 1'($urandom_range(1)); a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    for (int i = 0; i < hold; i++) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
    end
    r = result; e = err; z = zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0000", result); end
    n_checks++; if (zero !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got zero=%b err=%b want 0 0", zero, err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    logic [15:0] r; logic e, z; int lat; bit rl;
    do_op(3'd0, 8'd200, 8'd100, 0, r, e, z, lat, rl);
    n_checks++; if (r !== 16'h012C || e !== 1'b0) begin n_fail++; $display("FAIL add: got %h err=%b want 012c err=0", r, e); end
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
    do_op(3'd1, 8'd3, 8'd5, 0, r, e, z, lat, rl);
    n_checks++; if (r !== 16'hFFFE || e !== 1'b0 || z !== 1'b0) begin n_fail++; $display("FAIL sub: got %h err=%b zero=%b want fffe 0 0", r, e, z); end
  endtask

  task automatic test_mul();
    logic [15:0] r; logic e, z; int lat; bit rl;
    logic [16:0] m;
    do_op(3'd6, 8'd255, 8'd255, 0, r, e, z, lat, rl);
    m = model(3'd6, 8'd255, 8'd255);
    n_checks++; if (r !== m[15:0] || e !== m[16]) begin n_fail++; $display("FAIL mul: got %h err=%b want %h err=%b", r, e, m[15:0], m[16]); end
    n_checks++; if (lat != model_lat(3'd6, 8'd255)) begin n_fail++; $display("FAIL mul_latency: got %0d want %0d", lat, model_lat(3'd6, 8'd255)); end
    n_checks++; if (!rl) begin n_fail++; $display("FAIL mul_in_ready: got in_ready=1 while busy want 0"); end
    // small product covers the disabled-multiplier case too
    do_op(3'd6, 8'd3, 8'd4, 0, r, e, z, lat, rl);
    m = model(3'd6, 8'd3, 8'd4);
    n_checks++; if (r !== m[15:0] || e !== m[16] || z !== (m[15:0] == 16'h0)) begin n_fail++; $display("FAIL mul_small: got %h err=%b zero=%b want %h err=%b", r, e, z, m[15:0], m[16]); end
    n_checks++; if (lat != model_lat(3'd6, 8'd4)) begin n_fail++; $display("FAIL mul_small_latency: got %0d want %0d", lat, model_lat(3'd6, 8'd4)); end
  endtask

  task automatic test_div();
    logic [15:0] r; logic e, z; int lat; bit rl;
    do_op(3'd7, 8'd100, 8'd7, 0, r, e, z, lat, rl);
    n_checks++; if (r !== 16'h020E || e !== 1'b0) begin n_fail++; $display("FAIL div: got %h err=%b want 020e err=0", r, e); end
    n_checks++; if (lat != 9) begin n_fail++; $display("FAIL div_latency: got %0d want 9", lat); end
    do_op(3'd7, 8'd9, 8'd0, 0, r, e, z, lat, rl);
    n_checks++; if (r !== 16'h0 || e !== 1'b1 || z !== 1'b1) begin n_fail++; $display("FAIL div0: got %h err=%b zero=%b want 0000 1 1", r, e, z); end
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL div0_latency: got %0d want 1", lat); end
  endtask

  task automatic test_backpressure();
    int t;
    bit bad;
    op = 3'd4; a = 8'hF0; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 3'd0; a = 8'h11; b = 8'h22;   // keep a new command pending; must be ignored
    t = 0;
    while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (result !== 16'h000F || out_valid !== 1'b1 || in_ready !== 1'b0 || err !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL bp_hold: got result=%h out_valid=%b in_ready=%b want 000f 1 0", result, out_valid, in_ready); end
    n_checks++; if (result !== 16'h000F) begin n_fail++; $display("FAIL bp_result: got %h want 000f", result); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] r; logic e, z; int lat; bit rl;
    bit seen;
    op = 3'd7; a = 8'd100; b = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    n_checks++; if (result !== 16'h0 || zero !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h zero=%b err=%b want 0000 0 0", result, zero, err); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rst_mid_no_result: got out_valid=1 want 0"); end
    do_op(3'd0, 8'd1, 8'd1, 0, r, e, z, lat, rl);
    n_checks++; if (r !== 16'h0002 || e !== 1'b0 || lat != 1) begin n_fail++; $display("FAIL rst_mid_add: got %h err=%b lat=%0d want 0002 0 1", r, e, lat); end
  endtask

  task automatic test_random();
    logic [15:0] r; logic e, z; int lat; bit rl;
    logic [16:0] m;
    logic [2:0] o; logic [7:0] x, y;
    for (int n = 0; n < 60; n++) begin
      o = 3'($urandom_range(7));
      x = 8'($urandom);
      y = ($urandom_range(4) == 0) ? 8'd0 : 8'($urandom);
      do_op(o, x, y, $urandom_range(3), r, e, z, lat, rl);
      m = model(o, x, y);
      n_checks++;
      if (r !== m[15:0] || e !== m[16] || z !== (m[15:0] == 16'h0) || lat != model_lat(o, y) || !rl) begin
        n_fail++;
        $display("FAIL random op=%0d a=%h b=%h: got %h err=%b zero=%b lat=%0d rdy_low=%b want %h err=%b zero=%b lat=%0d",
                 o, x, y, r, e, z, lat, rl, m[15:0], m[16], (m[15:0] == 16'h0), model_lat(o, y));
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
